// File: rtl/vga_frame_scheduler_pkg.sv
// Shared geometry, colour codes, FSM encoding and span helpers for the
// TroisBriques frame scheduler and its pixel compositor.
package vga_frame_scheduler_pkg;

  localparam int CLK_DIV_DEF   = 2;
  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;

  localparam int BALL_SZ  = 8;
  localparam int PAD_W    = 64;
  localparam int PAD_H    = 8;
  localparam int PAD_Y    = 448;
  localparam int BRK_X0   = 80;
  localparam int BRK_W    = 120;
  localparam int BRK_GAP  = 40;
  localparam int BRK_Y    = 64;
  localparam int BRK_H    = 16;
  localparam int N_BRICKS = 3;

  localparam logic [2:0] RGB_BALL  = 3'b111;
  localparam logic [2:0] RGB_PAD   = 3'b011;
  localparam logic [2:0] RGB_BRICK = 3'b100;
  localparam logic [2:0] RGB_BG    = 3'b000;

  typedef enum logic [1:0] {
    ST_DRAW   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_LATCH  = 2'd2
  } state_e;

  typedef struct packed {
    logic [10:0]         ball_x;
    logic [10:0]         ball_y;
    logic [10:0]         pad_x;
    logic [N_BRICKS-1:0] brick_alive;
  } shadow_t;

  // Half-open [start, start+len) with a 12-bit end so objects near 2047 clip
  // instead of wrapping back to the left edge.
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] start,
                                   input logic [11:0] len);
    logic [11:0] stop;
    stop = {1'b0, start} + len;
    return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < stop);
  endfunction

  function automatic logic [10:0] brick_left(input int idx);
    return 11'(BRK_X0 + idx * (BRK_W + BRK_GAP));
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_pixel_compositor.sv
// Combinational hit tests of ball, paddle and bricks against the current
// pixel coordinate, resolved by fixed priority into a 3-bit colour.
module vga_frame_scheduler_pixel_compositor
  import vga_frame_scheduler_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF
) (
  input  logic [10:0]         hpos_i,
  input  logic [10:0]         vpos_i,
  input  logic [10:0]         ball_x_i,
  input  logic [10:0]         ball_y_i,
  input  logic [10:0]         pad_x_i,
  input  logic [N_BRICKS-1:0] brick_alive_i,
  output logic [2:0]          rgb_o
);

  logic                visible;
  logic                ball_hit;
  logic                pad_hit;
  logic                brick_row;
  logic [N_BRICKS-1:0] brick_hit;

  assign visible  = (hpos_i < 11'(H_VISIBLE)) && (vpos_i < 11'(V_VISIBLE));

  assign ball_hit = in_span(hpos_i, ball_x_i, 12'(BALL_SZ)) &&
                    in_span(vpos_i, ball_y_i, 12'(BALL_SZ));

  assign pad_hit  = in_span(hpos_i, pad_x_i, 12'(PAD_W)) &&
                    in_span(vpos_i, 11'(PAD_Y), 12'(PAD_H));

  assign brick_row = in_span(vpos_i, 11'(BRK_Y), 12'(BRK_H));

  genvar gi;
  generate
    for (gi = 0; gi < N_BRICKS; gi++) begin : g_brick
      assign brick_hit[gi] = brick_alive_i[gi] && brick_row &&
                             in_span(hpos_i, brick_left(gi), 12'(BRK_W));
    end
  endgenerate

  always_comb begin
    rgb_o = RGB_BG;
    if (!visible) begin
      rgb_o = RGB_BG;
    end else if (ball_hit) begin
      rgb_o = RGB_BALL;
    end else if (pad_hit) begin
      rgb_o = RGB_PAD;
    end else if (|brick_hit) begin
      rgb_o = RGB_BRICK;
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Pixel-enable divider, per-frame game update window with double-buffered
// object positions, and the 1-pixel output pipeline feeding the DAC.
module vga_frame_scheduler
  import vga_frame_scheduler_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  input  logic [10:0] Hpos,
  input  logic [10:0] Vpos,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] pad_x,
  input  logic [2:0]  brick_alive,
  output logic        update_req,
  input  logic        update_done,
  output logic        overrun,
  output logic [15:0] frame_cnt,
  output logic [2:0]  rgb,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic             update_req_q, update_req_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  shadow_t          shadow_q, shadow_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       comp_rgb;
  logic             window_open_evt;
  logic             window_close_evt;

  // pix_en decodes straight off the counter so it is low throughout reset.
  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign pix_en = (div_q == DIV_LAST);

  assign window_open_evt  = (Hpos == 11'd0) && (Vpos == 11'(V_VISIBLE));
  assign window_close_evt = (Hpos == 11'd0) && (Vpos == 11'd0);

  always_comb begin
    state_d      = state_q;
    update_req_d = update_req_q;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
    shadow_d     = shadow_q;
    case (state_q)
      ST_DRAW: begin
        if (pix_en && window_open_evt) begin
          state_d      = ST_UPDATE;
          update_req_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        // A done arriving on the closing pixel still counts as on time.
        if (pix_en && update_done) begin
          state_d      = ST_LATCH;
          update_req_d = 1'b0;
        end else if (pix_en && window_close_evt) begin
          state_d      = ST_DRAW;
          update_req_d = 1'b0;
          overrun_d    = 1'b1;
        end
      end
      ST_LATCH: begin
        state_d              = ST_DRAW;
        shadow_d.ball_x      = ball_x;
        shadow_d.ball_y      = ball_y;
        shadow_d.pad_x       = pad_x;
        shadow_d.brick_alive = brick_alive;
        frame_cnt_d          = frame_cnt_q + 16'd1;
      end
      default: begin
        state_d      = ST_DRAW;
        update_req_d = 1'b0;
      end
    endcase
  end

  vga_frame_scheduler_pixel_compositor #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE)
  ) u_compositor (
    .hpos_i        (Hpos),
    .vpos_i        (Vpos),
    .ball_x_i      (shadow_q.ball_x),
    .ball_y_i      (shadow_q.ball_y),
    .pad_x_i       (shadow_q.pad_x),
    .brick_alive_i (shadow_q.brick_alive),
    .rgb_o         (comp_rgb)
  );

  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = comp_rgb;
      hsync_d = Hsync;
      vsync_d = Vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      state_q      <= ST_DRAW;
      update_req_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= 16'd0;
      shadow_q     <= '0;
      rgb_q        <= RGB_BG;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      update_req_q <= update_req_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
      shadow_q     <= shadow_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign update_req = update_req_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;
  assign rgb        = rgb_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler: table of pixel vectors plus hand-written
// update-window sequences, expected outputs queued and popped after each pixel.
module tb_vga_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en;
  logic [10:0] Hpos = 11'd700;
  logic [10:0] Vpos = 11'd100;
  logic        Hsync = 1'b1;
  logic        Vsync = 1'b1;
  logic [10:0] ball_x = 11'd0;
  logic [10:0] ball_y = 11'd0;
  logic [10:0] pad_x = 11'd0;
  logic [2:0]  brick_alive = 3'b000;
  logic        update_req;
  logic        update_done = 1'b0;
  logic        overrun;
  logic [15:0] frame_cnt;
  logic [2:0]  rgb;
  logic        hsync_o;
  logic        vsync_o;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
  } vec_t;

  typedef struct {
    string      nm;
    logic [4:0] exp;
  } sb_t;

  vec_t tbl[13];
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  vga_frame_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .Hpos        (Hpos),
    .Vpos        (Vpos),
    .Hsync       (Hsync),
    .Vsync       (Vsync),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .pad_x       (pad_x),
    .brick_alive (brick_alive),
    .update_req  (update_req),
    .update_done (update_done),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt),
    .rgb         (rgb),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_pix();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_en && n < 8);
    if (!pix_en) chk("pix_en_timeout", 32'(pix_en), 32'd1);
  endtask

  // Present one pixel on a pix_en cycle; the registered result is checked after the edge.
  task automatic pix(input string nm, input logic [10:0] h, input logic [10:0] v,
                     input logic hs, input logic vs, input logic [2:0] er);
    sb_t        e;
    logic [4:0] act;
    wait_pix();
    Hpos  = h;
    Vpos  = v;
    Hsync = hs;
    Vsync = vs;
    e.nm  = nm;
    e.exp = {er, hs, vs};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    act = {rgb, hsync_o, vsync_o};
    $display("pix %s h=%0d v=%0d rgb=%b hs=%b vs=%b", e.nm, h, v, rgb, hsync_o, vsync_o);
    chk(e.nm, 32'(act), 32'(e.exp));
  endtask

  task automatic do_update(input logic [10:0] bx, input logic [10:0] by,
                           input logic [10:0] px, input logic [2:0] ba);
    ball_x      = bx;
    ball_y      = by;
    pad_x       = px;
    brick_alive = ba;
    pix("upd_open", 11'd0, 11'd480, 1'b0, 1'b0, 3'b000);
    chk("upd_req_open", 32'(update_req), 32'd1);
    update_done = 1'b1;
    pix("upd_done", 11'd5, 11'd480, 1'b1, 1'b0, 3'b000);
    update_done = 1'b0;
    chk("upd_req_closed", 32'(update_req), 32'd0);
    chk("upd_cnt_pre", 32'(frame_cnt), 32'(exp_frames));
    @(posedge clk);
    #1;
    exp_frames++;
    chk("upd_cnt_post", 32'(frame_cnt), 32'(exp_frames));
    @(posedge clk);
    #1;
    chk("upd_cnt_once", 32'(frame_cnt), 32'(exp_frames));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{11'd100, 11'd200, 1'b1, 1'b1, 3'b111};
    tbl[1]  = '{11'd96,  11'd448, 1'b0, 1'b1, 3'b011};
    tbl[2]  = '{11'd159, 11'd455, 1'b1, 1'b0, 3'b011};
    tbl[3]  = '{11'd160, 11'd448, 1'b0, 1'b0, 3'b000};
    tbl[4]  = '{11'd96,  11'd456, 1'b1, 1'b1, 3'b000};
    tbl[5]  = '{11'd107, 11'd207, 1'b0, 1'b1, 3'b111};
    tbl[6]  = '{11'd108, 11'd200, 1'b1, 1'b0, 3'b000};
    tbl[7]  = '{11'd240, 11'd64,  1'b1, 1'b1, 3'b100};
    tbl[8]  = '{11'd80,  11'd64,  1'b0, 1'b1, 3'b000};
    tbl[9]  = '{11'd359, 11'd79,  1'b1, 1'b0, 3'b100};
    tbl[10] = '{11'd360, 11'd64,  1'b0, 1'b0, 3'b000};
    tbl[11] = '{11'd240, 11'd80,  1'b1, 1'b1, 3'b000};
    tbl[12] = '{11'd239, 11'd70,  1'b0, 1'b1, 3'b000};

    repeat (5) @(posedge clk);
    #1;
    chk("rst_pix_en", 32'(pix_en), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_hsync", 32'(hsync_o), 32'd1);
    chk("rst_vsync", 32'(vsync_o), 32'd1);
    chk("rst_update_req", 32'(update_req), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    chk("pix_en_rel", 32'(pix_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("pix_en_seq%0d", k), 32'(pix_en), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    update_done = 1'b1;
    repeat (4) @(posedge clk);
    update_done = 1'b0;
    #1;
    chk("done_in_draw_cnt", 32'(frame_cnt), 32'd0);
    chk("done_in_draw_req", 32'(update_req), 32'd0);

    do_update(11'd100, 11'd200, 11'd96, 3'b010);
    for (int i = 0; i < 13; i++) begin
      pix($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].rgb);
    end

    do_update(11'd100, 11'd444, 11'd96, 3'b111);
    pix("ball_over_pad", 11'd103, 11'd448, 1'b1, 1'b1, 3'b111);
    pix("pad_left",      11'd96,  11'd448, 1'b1, 1'b1, 3'b011);
    pix("ball_corner",   11'd107, 11'd451, 1'b0, 1'b1, 3'b111);
    pix("pad_after",     11'd108, 11'd448, 1'b1, 1'b0, 3'b011);
    pix("brick0_live",   11'd80,  11'd64,  1'b1, 1'b1, 3'b100);

    ball_x      = 11'd636;
    ball_y      = 11'd300;
    pad_x       = 11'd2040;
    brick_alive = 3'b000;
    pix("dw_open", 11'd0, 11'd480, 1'b0, 1'b0, 3'b000);
    chk("dw_req", 32'(update_req), 32'd1);
    update_done = 1'b1;
    pix("dw_close", 11'd0, 11'd0, 1'b0, 1'b1, 3'b000);
    update_done = 1'b0;
    chk("dw_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    exp_frames++;
    chk("dw_cnt", 32'(frame_cnt), 32'(exp_frames));
    pix("edge_vis",   11'd639, 11'd300, 1'b1, 1'b1, 3'b111);
    pix("edge_clip",  11'd640, 11'd300, 1'b1, 1'b1, 3'b000);
    pix("no_wrap",    11'd10,  11'd448, 1'b1, 1'b1, 3'b000);
    pix("brick_dead", 11'd240, 11'd64,  1'b1, 1'b1, 3'b000);

    pix("ov_open", 11'd0, 11'd480, 1'b0, 1'b0, 3'b000);
    chk("ov_req", 32'(update_req), 32'd1);
    ball_x      = 11'd0;
    ball_y      = 11'd0;
    pad_x       = 11'd0;
    brick_alive = 3'b111;
    pix("ov_close", 11'd0, 11'd0, 1'b1, 1'b0, 3'b000);
    chk("ov_flag", 32'(overrun), 32'd1);
    chk("ov_req_low", 32'(update_req), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ov_cnt", 32'(frame_cnt), 32'(exp_frames));
    pix("ov_old_ball", 11'd639, 11'd300, 1'b1, 1'b1, 3'b111);
    pix("ov_no_stage", 11'd3,   11'd3,   1'b1, 1'b1, 3'b000);
    chk("ov_sticky", 32'(overrun), 32'd1);

    pix("rst_open", 11'd0, 11'd480, 1'b0, 1'b0, 3'b000);
    chk("rst_open_req", 32'(update_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_frames = 0;
    chk("mid_rst_req", 32'(update_req), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_hsync", 32'(hsync_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    pix("shadow_zero_ball", 11'd3,  11'd3,   1'b1, 1'b1, 3'b111);
    pix("shadow_zero_pad",  11'd20, 11'd448, 1'b1, 1'b1, 3'b011);
    do_update(11'd300, 11'd300, 11'd500, 3'b001);
    pix("post_rst_brick0", 11'd199, 11'd64, 1'b1, 1'b1, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
